// File: rtl/starfield_gen.sv
// Scrolling pseudo-random starfield for a raster pixel stream.
// A 17-bit Galois LFSR reloads at a per-frame moving pixel index; output is 1-cycle registered.
module starfield_gen #(
    parameter int unsigned CORDW   = 10,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned SPEED   = 1,
    parameter logic [16:0] SEED    = 17'h1FFFF,
    parameter logic [16:0] MASK    = 17'h12000,
    parameter int unsigned DENSITY = 8
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de_out,
    output logic             star_on,
    output logic [7:0]       star_bright
);

    localparam int unsigned NPIX = H_TOTAL * V_TOTAL;
    localparam int unsigned PW   = $clog2(NPIX);

    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW:0]   NPIX_W   = (PW + 1)'(NPIX);
    localparam logic [PW:0]   SPEED_W  = (PW + 1)'(SPEED);

    logic [PW-1:0] pos_q;
    logic [PW-1:0] offset_q;
    logic [PW-1:0] offset_d;
    logic [16:0]   lfsr_q;

    logic          frame_start;
    logic [PW-1:0] pix;
    logic [16:0]   step;
    logic [16:0]   lfsr_cur;
    logic [PW:0]   off_sum;
    logic          star;

    always_comb begin
        frame_start = (sx == '0) && (sy == '0);

        // Index wraps on its own so a missing frame_start cannot run it off the end.
        if (frame_start || (pos_q == LAST_PIX)) begin
            pix = '0;
        end else begin
            pix = pos_q + ONE;
        end

        step     = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : 17'h0);
        lfsr_cur = (pix == offset_q) ? SEED : step;

        // One extra bit so offset+SPEED cannot overflow before the modulo.
        off_sum  = {1'b0, offset_q} + SPEED_W;
        offset_d = offset_q;
        if (frame_start) begin
            if (off_sum >= NPIX_W) begin
                offset_d = PW'(off_sum - NPIX_W);
            end else begin
                offset_d = off_sum[PW-1:0];
            end
        end

        star = de_in && (&lfsr_cur[16 -: DENSITY]);
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            pos_q       <= '0;
            offset_q    <= '0;
            lfsr_q      <= SEED;
            hsync_out   <= 1'b1;
            vsync_out   <= 1'b1;
            de_out      <= 1'b0;
            star_on     <= 1'b0;
            star_bright <= 8'h00;
        end else begin
            pos_q       <= pix;
            offset_q    <= offset_d;
            lfsr_q      <= lfsr_cur;
            hsync_out   <= hsync_in;
            vsync_out   <= vsync_in;
            de_out      <= de_in;
            star_on     <= star;
            star_bright <= star ? lfsr_cur[7:0] : 8'h00;
        end
    end

endmodule

// File: tb/tb_starfield_gen.sv
// Randomised scoreboard bench for starfield_gen: one full-size and three 8x4 instances.
// The reference indexes a precomputed LFSR sequence by cycles elapsed since the last reload.
module tb_starfield_gen;

    localparam int NI  = 4;
    localparam int PER = 131071;
    localparam int unsigned HT [NI] = '{800, 8, 8, 8};
    localparam int unsigned VT [NI] = '{525, 4, 4, 4};
    localparam int unsigned SP [NI] = '{1, 1, 30, 0};
    localparam int unsigned DN [NI] = '{8, 1, 1, 1};

    logic       clk_pix = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sx0 = '0, sy0 = '0, sxs = '0, sys = '0;
    logic       hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0;
    logic       hs_o [NI];
    logic       vs_o [NI];
    logic       de_o [NI];
    logic       on_o [NI];
    logic [7:0] br_o [NI];

    always #5 clk_pix = ~clk_pix;

    starfield_gen #(.H_TOTAL(HT[0]), .V_TOTAL(VT[0]), .SPEED(SP[0]), .DENSITY(DN[0])) u0 (
        .clk_pix(clk_pix), .rst(rst), .sx(sx0), .sy(sy0), .hsync_in(hs_in), .vsync_in(vs_in),
        .de_in(de_in), .hsync_out(hs_o[0]), .vsync_out(vs_o[0]), .de_out(de_o[0]),
        .star_on(on_o[0]), .star_bright(br_o[0]));
    starfield_gen #(.H_TOTAL(HT[1]), .V_TOTAL(VT[1]), .SPEED(SP[1]), .DENSITY(DN[1])) u1 (
        .clk_pix(clk_pix), .rst(rst), .sx(sxs), .sy(sys), .hsync_in(hs_in), .vsync_in(vs_in),
        .de_in(de_in), .hsync_out(hs_o[1]), .vsync_out(vs_o[1]), .de_out(de_o[1]),
        .star_on(on_o[1]), .star_bright(br_o[1]));
    starfield_gen #(.H_TOTAL(HT[2]), .V_TOTAL(VT[2]), .SPEED(SP[2]), .DENSITY(DN[2])) u2 (
        .clk_pix(clk_pix), .rst(rst), .sx(sxs), .sy(sys), .hsync_in(hs_in), .vsync_in(vs_in),
        .de_in(de_in), .hsync_out(hs_o[2]), .vsync_out(vs_o[2]), .de_out(de_o[2]),
        .star_on(on_o[2]), .star_bright(br_o[2]));
    starfield_gen #(.H_TOTAL(HT[3]), .V_TOTAL(VT[3]), .SPEED(SP[3]), .DENSITY(DN[3])) u3 (
        .clk_pix(clk_pix), .rst(rst), .sx(sxs), .sy(sys), .hsync_in(hs_in), .vsync_in(vs_in),
        .de_in(de_in), .hsync_out(hs_o[3]), .vsync_out(vs_o[3]), .de_out(de_o[3]),
        .star_on(on_o[3]), .star_bright(br_o[3]));

    typedef struct packed {
        logic [NI-1:0]      hs;
        logic [NI-1:0]      vs;
        logic [NI-1:0]      de;
        logic [NI-1:0]      on;
        logic [NI-1:0][7:0] br;
    } exp_t;

    exp_t        sb[$];
    logic [16:0] seq [PER];
    int unsigned m_pos [NI];
    int unsigned m_off [NI];
    int unsigned m_age [NI];
    int          n_chk = 0;
    int          n_pass = 0;

    // seq[k] is the LFSR value k steps after a reload to the seed.
    task automatic build_seq();
        logic [16:0] v;
        v = 17'h1FFFF;
        for (int k = 0; k < PER; k++) begin
            seq[k] = v;
            v = {1'b0, v[16:1]} ^ (v[0] ? 17'h12000 : 17'h0);
        end
    endtask

    task automatic chk(input string name, input int inst, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [9:0] a_sx0, input logic [9:0] a_sy0,
                         input logic [9:0] a_sxs, input logic [9:0] a_sys,
                         input logic h, input logic v, input logic d);
        exp_t        e;
        int unsigned n, pix, top;
        logic [9:0]  cx, cy;
        logic [16:0] cur;
        logic        star;
        @(negedge clk_pix);
        rst = r; sx0 = a_sx0; sy0 = a_sy0; sxs = a_sxs; sys = a_sys;
        hs_in = h; vs_in = v; de_in = d;
        e = '0;
        for (int i = 0; i < NI; i++) begin
            cx = (i == 0) ? a_sx0 : a_sxs;
            cy = (i == 0) ? a_sy0 : a_sys;
            if (r) begin
                e.hs[i] = 1'b1; e.vs[i] = 1'b1; e.de[i] = 1'b0; e.on[i] = 1'b0; e.br[i] = 8'h00;
                m_pos[i] = 0; m_off[i] = 0; m_age[i] = 0;
            end else begin
                n   = HT[i] * VT[i];
                pix = (cx == 0 && cy == 0) ? 0 : (m_pos[i] + 1) % n;
                m_age[i] = (pix == m_off[i]) ? 0 : (m_age[i] + 1) % PER;
                cur  = seq[m_age[i]];
                top  = 32'(cur) >> (17 - DN[i]);
                star = d && (top == (32'd1 << DN[i]) - 1);
                e.hs[i] = h; e.vs[i] = v; e.de[i] = d; e.on[i] = star;
                e.br[i] = star ? cur[7:0] : 8'h00;
                m_pos[i] = pix;
                if (cx == 0 && cy == 0) m_off[i] = (m_off[i] + SP[i]) % n;
            end
        end
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_pix);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < NI; i++) begin
                    chk("hsync_out", i, {7'd0, hs_o[i]}, {7'd0, e.hs[i]});
                    chk("vsync_out", i, {7'd0, vs_o[i]}, {7'd0, e.vs[i]});
                    chk("de_out", i, {7'd0, de_o[i]}, {7'd0, e.de[i]});
                    chk("star_on", i, {7'd0, on_o[i]}, {7'd0, e.on[i]});
                    chk("star_bright", i, br_o[i], e.br[i]);
                end
            end
        end
    end

    initial begin
        int unsigned sp, bp;
        logic        r, h, v, d, mid_done;
        logic [4:0]  pat;
        logic [9:0]  a_sxs, a_sys;
        build_seq();
        sp = 0; bp = 0; mid_done = 1'b0;
        pat = 5'b01101;  // de/hs/vs sequence 1,0,1,1,0 read from bit 0 upward
        for (int c = 0; c < 1300; c++) begin
            if (c < 3) begin
                drive(1'b1, 10'd5, 10'd7, 10'd5, 10'd7, 1'b0, 1'b1, 1'b1);
            end else begin
                r = 1'b0;
                if (!mid_done && c >= 600 && (sp % 32) == 13) begin
                    r = 1'b1;
                    mid_done = 1'b1;
                end
                if (c - 3 < 5) begin
                    d = pat[c-3]; h = pat[c-3]; v = pat[c-3];
                end else begin
                    d = ($urandom_range(0, 3) != 0);
                    h = 1'($urandom);
                    v = 1'($urandom);
                end
                if (c >= 300 && c < 340) begin
                    a_sxs = 10'd1; a_sys = 10'd0;
                end else begin
                    a_sxs = 10'(sp % 8); a_sys = 10'((sp / 8) % 4);
                    sp++;
                end
                drive(r, 10'(bp % 800), 10'((bp / 800) % 525), a_sxs, a_sys, h, v, d);
                bp++;
            end
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk_pix);
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
